// File: rtl/gst_dmasnd_engine.sv
// DMA sound playback engine: sample FIFO fed by SLOAD_N strobes, rate-paced
// playback in 8/16-bit stereo/mono, offset-binary left/right outputs.
module gst_dmasnd_engine #(
  parameter int FIFO_ADDR_BITS = 3,
  parameter int BASE_DIV       = 640,
  parameter int REQ_MARGIN     = 2,
  parameter int OUT_W          = 8
) (
  input  logic                    clk32,
  input  logic                    resb,
  input  logic                    enable,
  input  logic [3:0]              mode,
  input  logic                    SLOAD_N,
  input  logic [15:0]             MDIN,
  output logic                    SREQ,
  output logic [FIFO_ADDR_BITS:0] level,
  output logic                    underrun,
  output logic                    overflow,
  input  logic                    clr_status,
  output logic [OUT_W-1:0]        audio_left,
  output logic [OUT_W-1:0]        audio_right
);

  localparam int AW    = FIFO_ADDR_BITS;
  localparam int LW    = FIFO_ADDR_BITS + 1;
  localparam int DEPTH = 1 << AW;
  localparam int DW    = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [LW-1:0]    DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0]    MARGIN_L = LW'(REQ_MARGIN);
  localparam logic [DW-1:0]    DIV_LAST = DW'(BASE_DIV - 1);
  localparam logic [OUT_W-1:0] MID      = {1'b1, {(OUT_W-1){1'b0}}};

  logic [15:0] mem [DEPTH];

  logic [DW-1:0]    base_cnt_reg;
  logic             base_en_reg;
  logic [2:0]       aclk_cnt_reg;
  logic             strobe_reg;
  logic             sload_d_reg;
  logic [3:0]       mode_reg;
  logic             phase_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             underrun_reg;
  logic             overflow_reg;
  logic [OUT_W-1:0] left_reg;
  logic [OUT_W-1:0] right_reg;

  logic          full;
  logic          wr_req;
  logic          wr_ok;
  logic          ovf_set;
  logic          rate_ok;
  logic          play;
  logic          enough;
  logic          take;
  logic          udr_set;
  logic          toggle;
  logic [1:0]    pop_need;
  logic [1:0]    pop_cnt;
  logic [7:0]    mono_byte;
  logic [15:0]   word0;
  logic [15:0]   word1;
  logic [15:0]   src_l;
  logic [15:0]   src_r;
  logic [AW-1:0] rd_ptr_p1;

  // Top OUT_W bits of a signed 16-bit value, sign flipped to offset binary.
  function automatic logic [OUT_W-1:0] conv(input logic [15:0] src);
    logic [OUT_W-1:0] t;
    t = src[15 -: OUT_W];
    t[OUT_W-1] = ~t[OUT_W-1];
    return t;
  endfunction

  assign full      = (level_reg == DEPTH_L);
  assign wr_req    = sload_d_reg & ~SLOAD_N & enable;
  assign wr_ok     = wr_req & ~full;
  assign ovf_set   = wr_req & full;
  assign rd_ptr_p1 = rd_ptr_reg + AW'(1);
  assign word0     = mem[rd_ptr_reg];
  assign word1     = mem[rd_ptr_p1];

  assign SREQ        = enable & ((DEPTH_L - level_reg) > MARGIN_L);
  assign level       = level_reg;
  assign underrun    = underrun_reg;
  assign overflow    = overflow_reg;
  assign audio_left  = left_reg;
  assign audio_right = right_reg;

  always_comb begin
    rate_ok = 1'b0;
    case (mode_reg[1:0])
      2'b11:   rate_ok = 1'b1;
      2'b10:   rate_ok = ~aclk_cnt_reg[0];
      2'b01:   rate_ok = (aclk_cnt_reg[1:0] == 2'b00);
      default: rate_ok = (aclk_cnt_reg == 3'b000);
    endcase
  end

  always_comb begin
    mono_byte = phase_reg ? word0[7:0] : word0[15:8];
    src_l     = word0;
    src_r     = word0;
    pop_need  = 2'd1;
    toggle    = 1'b0;
    enough    = (level_reg != '0);
    case (mode_reg[3:2])
      2'b00: begin
        src_l = {word0[15:8], 8'h00};
        src_r = {word0[7:0], 8'h00};
      end
      2'b01: begin
        src_l    = {mono_byte, 8'h00};
        src_r    = {mono_byte, 8'h00};
        pop_need = {1'b0, phase_reg};
        toggle   = 1'b1;
      end
      2'b10: begin
        src_r    = word1;
        pop_need = 2'd2;
        enough   = (level_reg >= LW'(2));
      end
      default: ;
    endcase
    play    = strobe_reg & enable;
    take    = play & enough;
    udr_set = play & ~enough;
    pop_cnt = take ? pop_need : 2'd0;
  end

  // Sample storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk32) begin
    if (wr_ok) mem[wr_ptr_reg] <= MDIN;
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      base_cnt_reg <= '0;
      base_en_reg  <= 1'b0;
      aclk_cnt_reg <= '0;
      strobe_reg   <= 1'b0;
      sload_d_reg  <= 1'b1;
      mode_reg     <= '0;
      phase_reg    <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      underrun_reg <= 1'b0;
      overflow_reg <= 1'b0;
      left_reg     <= MID;
      right_reg    <= MID;
    end else begin
      base_cnt_reg <= (base_cnt_reg == DIV_LAST) ? '0 : base_cnt_reg + DW'(1);
      base_en_reg  <= (base_cnt_reg == '0);
      if (base_en_reg) aclk_cnt_reg <= aclk_cnt_reg + 3'd1;
      strobe_reg   <= base_en_reg & rate_ok;
      sload_d_reg  <= SLOAD_N;
      mode_reg     <= mode;

      // A set in the same cycle as a clear must win.
      if (udr_set)         underrun_reg <= 1'b1;
      else if (clr_status) underrun_reg <= 1'b0;
      if (ovf_set)         overflow_reg <= 1'b1;
      else if (clr_status) overflow_reg <= 1'b0;

      if (!enable) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
        phase_reg  <= 1'b0;
        left_reg   <= MID;
        right_reg  <= MID;
      end else begin
        if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        rd_ptr_reg <= rd_ptr_reg + AW'(pop_cnt);
        level_reg  <= level_reg + LW'(wr_ok) - LW'(pop_cnt);
        if (take) begin
          left_reg  <= conv(src_l);
          right_reg <= conv(src_r);
        end
        if (mode != mode_reg)   phase_reg <= 1'b0;
        else if (take & toggle) phase_reg <= ~phase_reg;
      end
    end
  end

endmodule

// File: tb/tb_gst_dmasnd_engine.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based playback model.
module tb_gst_dmasnd_engine;

  localparam int AB     = 3;
  localparam int DEPTH  = 1 << AB;
  localparam int DIV    = 640;
  localparam int MARGIN = 2;
  localparam int OUT_W  = 16;
  localparam int MID    = 1 << (OUT_W - 1);

  logic             clk32 = 1'b0;
  logic             resb = 1'b1;
  logic             enable = 1'b0;
  logic [3:0]       mode = 4'h0;
  logic             SLOAD_N = 1'b1;
  logic [15:0]      MDIN = 16'h0;
  logic             SREQ;
  logic [AB:0]      level;
  logic             underrun;
  logic             overflow;
  logic             clr_status = 1'b0;
  logic [OUT_W-1:0] audio_left;
  logic [OUT_W-1:0] audio_right;

  gst_dmasnd_engine #(
    .FIFO_ADDR_BITS(AB), .BASE_DIV(DIV), .REQ_MARGIN(MARGIN), .OUT_W(OUT_W)
  ) dut (
    .clk32(clk32), .resb(resb), .enable(enable), .mode(mode),
    .SLOAD_N(SLOAD_N), .MDIN(MDIN), .SREQ(SREQ), .level(level),
    .underrun(underrun), .overflow(overflow), .clr_status(clr_status),
    .audio_left(audio_left), .audio_right(audio_right)
  );

  always #5 clk32 = ~clk32;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  int          strobe_cnt = 0;
  logic [15:0] m_q[$];
  int          m_left = MID;
  int          m_right = MID;
  bit          m_phase = 1'b0;
  bit          m_udr = 1'b0;
  bit          m_ovf = 1'b0;
  bit          sload_prev = 1'b1;
  logic [3:0]  mode_h1 = 4'h0;
  logic [3:0]  mode_h2 = 4'h0;
  int          sz;
  int          tick;
  bit          wr_edge, play_now, ok, uset, oset;
  logic [15:0] w0, w1;
  logic [7:0]  b;

  function automatic int conv(input logic [15:0] s);
    logic [15:0] t;
    t = s ^ 16'h8000;
    t = t >> (16 - OUT_W);
    return int'(t);
  endfunction

  always @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      m_q.delete();
      cyc = 0; m_phase = 0; m_left = MID; m_right = MID;
      m_udr = 0; m_ovf = 0; sload_prev = 1; mode_h1 = 0; mode_h2 = 0;
    end else begin
      cyc++;
      wr_edge = sload_prev && !SLOAD_N;
      sload_prev = SLOAD_N;
      // Playback edges: one base tick every DIV cycles, acted on two cycles later.
      play_now = 0;
      if (cyc >= 3 && (cyc - 3) % DIV == 0) begin
        tick = ((cyc - 3) / DIV) % 8;
        case (mode_h2[1:0])
          2'b11:   play_now = 1;
          2'b10:   play_now = (tick % 2 == 0);
          2'b01:   play_now = (tick % 4 == 0);
          default: play_now = (tick == 0);
        endcase
        if (play_now) strobe_cnt++;
      end
      uset = 0; oset = 0;
      if (!enable) begin
        m_q.delete(); m_phase = 0; m_left = MID; m_right = MID;
      end else begin
        sz = m_q.size();
        if (play_now) begin
          ok = (mode_h1[3:2] == 2'b10) ? (sz >= 2) : (sz >= 1);
          if (!ok) uset = 1;
          else begin
            w0 = m_q[0];
            w1 = (sz >= 2) ? m_q[1] : 16'h0;
            case (mode_h1[3:2])
              2'b00: begin
                m_left = conv({w0[15:8], 8'h00}); m_right = conv({w0[7:0], 8'h00});
                void'(m_q.pop_front());
              end
              2'b01: begin
                b = m_phase ? w0[7:0] : w0[15:8];
                m_left = conv({b, 8'h00}); m_right = m_left;
                if (m_phase) void'(m_q.pop_front());
                m_phase = !m_phase;
              end
              2'b10: begin
                m_left = conv(w0); m_right = conv(w1);
                void'(m_q.pop_front()); void'(m_q.pop_front());
              end
              default: begin
                m_left = conv(w0); m_right = m_left;
                void'(m_q.pop_front());
              end
            endcase
          end
        end
        if (wr_edge) begin
          if (sz == DEPTH) oset = 1;
          else m_q.push_back(MDIN);
        end
        if (mode != mode_h1) m_phase = 0;
      end
      if (uset) m_udr = 1; else if (clr_status) m_udr = 0;
      if (oset) m_ovf = 1; else if (clr_status) m_ovf = 0;
      mode_h2 = mode_h1;
      mode_h1 = mode;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk32) begin
    if (resb && chk_on) begin
      check("level", level, m_q.size());
      check("sreq", SREQ, (enable && (DEPTH - int'(m_q.size()) > MARGIN)) ? 1 : 0);
      check("underrun", underrun, m_udr);
      check("overflow", overflow, m_ovf);
      check("left", audio_left, m_left);
      check("right", audio_right, m_right);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic write_word(input logic [15:0] w);
    MDIN = w; SLOAD_N = 0;
    @(negedge clk32);
    SLOAD_N = 1;
    @(negedge clk32);
  endtask

  task automatic pulse_clr();
    clr_status = 1;
    @(negedge clk32);
    clr_status = 0;
  endtask

  task automatic wait_strobe();
    int s0;
    bit hit;
    s0 = strobe_cnt; hit = 0;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk32);
      if (strobe_cnt != s0) begin hit = 1; break; end
    end
    if (!hit) check("strobe_timeout", 0, 1);
  endtask

  task automatic wait_rise(output int t);
    bit hit;
    hit = 0; t = 0;
    for (int n = 0; n < 6000; n++) begin
      if (underrun === 1'b1) begin hit = 1; t = cyc; break; end
      @(negedge clk32);
    end
    if (!hit) check("underrun_timeout", 0, 1);
  endtask

  int t1, t2, wr_period;

  initial begin
    @(negedge clk32);
    resb = 0;
    repeat (3) @(negedge clk32);
    check("rst_level", level, 0);
    check("rst_sreq", SREQ, 0);
    check("rst_left", audio_left, 16'h8000);
    check("rst_right", audio_right, 16'h8000);
    check("rst_udr", underrun, 0);
    check("rst_ovf", overflow, 0);

    resb = 1; chk_on = 1; enable = 1; mode = 4'b0011;
    @(negedge clk32);
    check("en_sreq", SREQ, 1);

    // empty FIFO at rate 11: first strobe flags underrun
    wait_strobe();
    check("empty_udr", underrun, 1);
    pulse_clr();
    check("clr_udr", underrun, 0);

    // 8-bit stereo
    write_word(16'h7F80);
    check("st8_lvl1", level, 1);
    wait_strobe();
    check("st8_left", audio_left, 16'hFF00);
    check("st8_right", audio_right, 16'h0000);
    check("st8_lvl0", level, 0);
    check("st8_sreq", SREQ, 1);
    check("model_st8_left", m_left, 16'hFF00);

    // strobe spacing at rate 11
    wait_rise(t1);
    pulse_clr();
    wait_rise(t2);
    check("spacing_11", t2 - t1, 640);

    // strobe spacing at rate 00
    mode = 4'b0000;
    pulse_clr();
    wait_rise(t1);
    pulse_clr();
    wait_rise(t1);
    pulse_clr();
    wait_rise(t2);
    check("spacing_00", t2 - t1, 5120);

    // 8-bit mono
    mode = 4'b0111;
    pulse_clr();
    write_word(16'h1020);
    wait_strobe();
    check("mono_l1", audio_left, 16'h9000);
    check("mono_r1", audio_right, 16'h9000);
    check("mono_lvl1", level, 1);
    wait_strobe();
    check("mono_l2", audio_left, 16'hA000);
    check("mono_r2", audio_right, 16'hA000);
    check("mono_lvl2", level, 0);

    // 16-bit stereo with a short FIFO
    enable = 0;
    @(negedge clk32);
    enable = 1; mode = 4'b1011;
    check("flush_mid", audio_left, 16'h8000);
    write_word(16'h8000);
    wait_strobe();
    check("st16_udr", underrun, 1);
    check("st16_hold_l", audio_left, 16'h8000);
    check("st16_hold_r", audio_right, 16'h8000);
    check("st16_lvl1", level, 1);
    pulse_clr();
    write_word(16'h7FFF);
    wait_strobe();
    check("st16_left", audio_left, 16'h0000);
    check("st16_right", audio_right, 16'hFFFF);
    check("st16_lvl0", level, 0);
    check("model_st16_right", m_right, 16'hFFFF);

    // fill, watermark and overflow
    mode = 4'b1111;
    for (int i = 0; i < 5; i++) write_word(16'(i * 16'h0101));
    check("fill5_lvl", level, 5);
    check("fill5_sreq", SREQ, 1);
    write_word(16'h0505);
    check("fill6_sreq", SREQ, 0);
    write_word(16'h0606);
    write_word(16'h0707);
    check("fill8_lvl", level, 8);
    check("fill8_ovf", overflow, 0);
    write_word(16'h0808);
    check("ovf_set", overflow, 1);
    check("ovf_lvl", level, 8);
    pulse_clr();
    check("ovf_clr", overflow, 0);
    enable = 0;
    @(negedge clk32);
    check("dis_lvl", level, 0);
    check("dis_sreq", SREQ, 0);
    enable = 1;

    // write and pop on the same edge at level 3
    wait_strobe();
    write_word(16'h1111);
    write_word(16'h2222);
    write_word(16'h3333);
    check("wp_lvl_pre", level, 3);
    for (int n = 0; n < 700; n++) begin
      if ((cyc + 1 - 3) % DIV == 0) break;
      @(negedge clk32);
    end
    MDIN = 16'h4444; SLOAD_N = 0;
    @(negedge clk32);
    SLOAD_N = 1;
    check("wp_lvl", level, 3);
    check("wp_left", audio_left, 16'h9111);
    enable = 0;
    @(negedge clk32);
    check("wp_dis_lvl", level, 0);
    check("wp_dis_sreq", SREQ, 0);
    check("wp_dis_left", audio_left, 16'h8000);
    check("wp_dis_right", audio_right, 16'h8000);
    enable = 1;

    // randomized traffic
    wr_period = 100;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk32);
      if (i % 4000 == 0) wr_period = $urandom_range(15, 400);
      if (!SLOAD_N) SLOAD_N = 1;
      else if ($urandom_range(0, wr_period - 1) == 0) begin
        SLOAD_N = 0;
        MDIN = 16'($urandom);
      end
      clr_status = ($urandom_range(0, 799) == 0);
      if (!enable) enable = ($urandom_range(0, 7) == 0);
      else if ($urandom_range(0, 9999) == 0) enable = 0;
      if ($urandom_range(0, 2999) == 0) begin
        mode[3:2] = 2'($urandom);
        mode[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      end
    end
    SLOAD_N = 1; clr_status = 0;
    repeat (4) @(negedge clk32);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
